// File: rtl/serial_compare16.sv
// Multi-nibble magnitude comparator: latches A/B, scans MSB nibble first one
// nibble per clock, stops on the first difference, emits a one-hot relation.
module serial_compare16 #(
    parameter int NIBBLES = 4
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic                 iStart,
    input  logic [4*NIBBLES-1:0] iData_a,
    input  logic [4*NIBBLES-1:0] iData_b,
    input  logic [2:0]           iCascade,
    output logic [2:0]           oData,
    output logic                 oBusy,
    output logic                 oDone,
    output logic [2:0]           oNibble_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [2:0] REL_GT = 3'b100;
    localparam logic [2:0] REL_EQ = 3'b010;
    localparam logic [2:0] REL_LT = 3'b001;

    state_t               state_q;
    logic [4*NIBBLES-1:0] a_q;
    logic [4*NIBBLES-1:0] b_q;
    logic [2:0]           casc_q;
    logic [2:0]           idx_q;
    logic [2:0]           data_q;
    logic                 busy_q;
    logic                 done_q;

    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [2:0] casc_norm;

    assign nib_a = a_q[4*idx_q +: 4];
    assign nib_b = b_q[4*idx_q +: 4];

    // Anything other than a single set bit is treated as "equal".
    assign casc_norm = $onehot(iCascade) ? iCascade : REL_EQ;

    // NOTE: operand latches sit in the reset domain too, so a reset leaves no
    // stale operand behind for the next compare to pick up.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            casc_q  <= REL_EQ;
            idx_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: every state register uses <=, so all branches below see
            // the pre-edge values and update together at the edge.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (iStart) begin
                        a_q     <= iData_a;
                        b_q     <= iData_b;
                        casc_q  <= casc_norm;
                        idx_q   <= 3'(NIBBLES - 1);
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (nib_a != nib_b || idx_q == 3'd0) begin
                        if (nib_a > nib_b)      data_q <= REL_GT;
                        else if (nib_a < nib_b) data_q <= REL_LT;
                        else                    data_q <= casc_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        idx_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        idx_q <= idx_q - 3'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign oData       = data_q;
    assign oBusy       = busy_q;
    assign oDone       = done_q;
    assign oNibble_cnt = idx_q;

endmodule

// File: tb/tb_serial_compare16.sv
// Directed self-checking bench for serial_compare16 (NIBBLES=4).
module tb_serial_compare16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] data_a;
    logic [15:0] data_b;
    logic [2:0]  cascade;
    logic [2:0]  o_data;
    logic        o_busy;
    logic        o_done;
    logic [2:0]  o_cnt;

    int checks = 0;
    int errors = 0;

    serial_compare16 #(.NIBBLES(4)) dut (
        .iClk        (clk),
        .iRst_n      (rst_n),
        .iStart      (start),
        .iData_a     (data_a),
        .iData_b     (data_b),
        .iCascade    (cascade),
        .oData       (o_data),
        .oBusy       (o_busy),
        .oDone       (o_done),
        .oNibble_cnt (o_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a compare, scramble inputs afterwards, expect result k edges later.
    task automatic run_compare(input string tag, input logic [15:0] a, input logic [15:0] b,
                               input logic [2:0] c, input int k, input logic [2:0] exp_data);
        data_a  = a;
        data_b  = b;
        cascade = c;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        data_a  = 16'(~a);
        data_b  = 16'($urandom);
        cascade = 3'b111;
        check({tag, "_busy_e0"}, 16'(o_busy), 16'd1);
        check({tag, "_cnt_e0"}, 16'(o_cnt), 16'd3);
        for (int i = 1; i < k; i++) begin
            tick();
            check({tag, "_busy_scan"}, 16'(o_busy), 16'd1);
            check({tag, "_done_scan"}, 16'(o_done), 16'd0);
            check({tag, "_cnt_scan"}, 16'(o_cnt), 16'(3 - i));
        end
        tick();
        check({tag, "_done"}, 16'(o_done), 16'd1);
        check({tag, "_busy_end"}, 16'(o_busy), 16'd0);
        check({tag, "_data"}, 16'(o_data), 16'(exp_data));
        check({tag, "_cnt_end"}, 16'(o_cnt), 16'd0);
        tick();
        check({tag, "_done_fall"}, 16'(o_done), 16'd0);
        check({tag, "_data_hold"}, 16'(o_data), 16'(exp_data));
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        data_a  = '0;
        data_b  = '0;
        cascade = 3'b010;
        #2;
        check("rst_data", 16'(o_data), 16'd0);
        check("rst_busy", 16'(o_busy), 16'd0);
        check("rst_done", 16'(o_done), 16'd0);
        check("rst_cnt", 16'(o_cnt), 16'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_busy", 16'(o_busy), 16'd0);

        // Equal operands, cascade passes through; a re-pulse mid-scan is ignored.
        data_a  = 16'hA5C3;
        data_b  = 16'hA5C3;
        cascade = 3'b001;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("c1_busy_e0", 16'(o_busy), 16'd1);
        check("c1_cnt_e0", 16'(o_cnt), 16'd3);
        tick();
        check("c1_cnt_e1", 16'(o_cnt), 16'd2);
        check("c1_data_none", 16'(o_data), 16'd0);
        data_a = 16'hFFFF;
        data_b = 16'h0000;
        start  = 1'b1;
        tick();
        start = 1'b0;
        check("c1_cnt_e2", 16'(o_cnt), 16'd1);
        check("c1_busy_e2", 16'(o_busy), 16'd1);
        tick();
        check("c1_cnt_e3", 16'(o_cnt), 16'd0);
        check("c1_busy_e3", 16'(o_busy), 16'd1);
        check("c1_done_e3", 16'(o_done), 16'd0);
        data_a  = 16'h0001;
        data_b  = 16'h0002;
        cascade = 3'b100;
        start   = 1'b1;
        tick();
        check("c1_done_e4", 16'(o_done), 16'd1);
        check("c1_busy_e4", 16'(o_busy), 16'd0);
        check("c1_data_e4", 16'(o_data), 16'b001);

        // Back-to-back accept at the oDone edge.
        tick();
        start = 1'b0;
        check("b2b_done_fall", 16'(o_done), 16'd0);
        check("b2b_busy", 16'(o_busy), 16'd1);
        check("b2b_cnt", 16'(o_cnt), 16'd3);
        check("b2b_data_hold", 16'(o_data), 16'b001);
        tick();
        tick();
        tick();
        check("b2b_done_e3", 16'(o_done), 16'd0);
        check("b2b_cnt_e3", 16'(o_cnt), 16'd0);
        tick();
        check("b2b_done_e4", 16'(o_done), 16'd1);
        check("b2b_data_e4", 16'(o_data), 16'b001);
        tick();
        check("b2b_done_fall2", 16'(o_done), 16'd0);

        run_compare("early_gt", 16'hA5C3, 16'h95C3, 3'b010, 1, 3'b100);
        run_compare("late_lt", 16'h1234, 16'h1235, 3'b100, 4, 3'b001);
        run_compare("bad_casc", 16'h0F0F, 16'h0F0F, 3'b011, 4, 3'b010);
        run_compare("zero_casc", 16'h0000, 16'h0000, 3'b000, 4, 3'b010);
        run_compare("gt_casc", 16'hFFFF, 16'hFFFF, 3'b100, 4, 3'b100);
        run_compare("second_gt", 16'hA5C3, 16'hA4C3, 3'b001, 2, 3'b100);
        run_compare("third_lt", 16'h7730, 16'h7740, 3'b100, 3, 3'b001);

        // Reset mid-scan at idx=2 aborts without a done pulse.
        data_a  = 16'h1111;
        data_b  = 16'h1111;
        cascade = 3'b100;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("rst_mid_cnt_before", 16'(o_cnt), 16'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 16'(o_busy), 16'd0);
        check("rst_mid_done", 16'(o_done), 16'd0);
        check("rst_mid_data", 16'(o_data), 16'd0);
        check("rst_mid_cnt", 16'(o_cnt), 16'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_no_done", 16'(o_done), 16'd0);
        end
        run_compare("post_rst", 16'h8000, 16'h7FFF, 3'b010, 1, 3'b100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
